eth_rx_frame_filter_fifo: RTL and testbench

Store-and-forward frame buffer placed directly after the GMII frame receiver. It consumes the receiver's AXI-Stream output, which has no tready, and buffers each frame. A frame is committed only if it ended good (tuser=0), passed the destination-MAC filter and fit in the buffer; all other frames are silently discarded. Committed frames are replayed on a backpressurable AXI-Stream master towards the Ethernet header parser.

---
 rtl/eth_rx_frame_filter_fifo.sv | 166 ++++++++++++++++
 tb/tb_eth_rx_frame_filter_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_filter_fifo.sv
// Store-and-forward buffer behind the GMII receiver: frames are written speculatively
// and committed only when good, address-matched and fully stored; otherwise rolled back.
module eth_rx_frame_filter_fifo #(
  parameter int DATA_WIDTH        = 8,
  parameter int DEPTH             = 2048,
  parameter bit MAC_FILTER_ENABLE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  input  logic [47:0]           local_mac,
  input  logic                  promisc,
  output logic                  status_good_frame,
  output logic                  status_bad_frame,
  output logic                  status_filtered,
  output logic                  status_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("eth_rx_frame_filter_fifo: only DATA_WIDTH=8 is supported");
  end
  if (DEPTH < 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("eth_rx_frame_filter_fifo: DEPTH must be a power of two >= 64");
  end

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [DATA_WIDTH:0] ram_q;

  logic [AW:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q;
  logic        drop_q, drop_d, mism_q, mism_d, bcast_q, bcast_d, mcast_q, mcast_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  stat_q, stat_d;   // {good, bad, filtered, overflow}

  logic        full, empty, wr_en, fetch, out_rdy, addr_ok;
  logic        ram_vld_q, m_tvalid_q, m_tlast_q;
  logic [DATA_WIDTH-1:0] m_tdata_q;
  logic [7:0]  mac_byte;

  assign full  = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  assign empty = rd_ptr_q == wr_commit_q;

  always_comb begin
    case (cnt_q)
      3'd0:    mac_byte = local_mac[47:40];
      3'd1:    mac_byte = local_mac[39:32];
      3'd2:    mac_byte = local_mac[31:24];
      3'd3:    mac_byte = local_mac[23:16];
      3'd4:    mac_byte = local_mac[15:8];
      3'd5:    mac_byte = local_mac[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    drop_d      = drop_q;
    mism_d      = mism_q;
    bcast_d     = bcast_q;
    mcast_d     = mcast_q;
    cnt_d       = cnt_q;
    stat_d      = 4'b0000;
    wr_en       = 1'b0;
    addr_ok     = 1'b0;
    if (s_axis_tvalid) begin
      wr_en = !drop_q && !full;
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (full)  drop_d = 1'b1;
      if (cnt_q < 3'd6) begin
        mism_d  = mism_q  | (s_axis_tdata != mac_byte);
        bcast_d = bcast_q & (s_axis_tdata == 8'hFF);
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd0) mcast_d = s_axis_tdata[0];
      end
      if (s_axis_tlast) begin
        // Uses the updated flags so the sixth byte counts when it is also the last.
        addr_ok = !mism_d || bcast_d || mcast_d || promisc || !MAC_FILTER_ENABLE;
        if (drop_q || full) begin
          wr_ptr_d  = wr_commit_q;
          stat_d[0] = 1'b1;
        end else if (s_axis_tuser || cnt_q < 3'd5) begin
          wr_ptr_d  = wr_commit_q;
          stat_d[2] = 1'b1;
        end else if (!addr_ok) begin
          wr_ptr_d  = wr_commit_q;
          stat_d[1] = 1'b1;
        end else begin
          wr_commit_d = wr_ptr_q + PTR_ONE;
          stat_d[3]   = 1'b1;
        end
        cnt_d   = 3'd0;
        drop_d  = 1'b0;
        mism_d  = 1'b0;
        bcast_d = 1'b1;
        mcast_d = 1'b0;
      end
    end
  end

  // Read pipeline: RAM register stage then output register; the RAM stage refills
  // whenever it is empty or draining, giving one beat per cycle under ready.
  assign out_rdy = !m_tvalid_q || m_axis_tready;
  assign fetch   = !empty && (!ram_vld_q || out_rdy);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    if (fetch) ram_q <= mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      drop_q      <= 1'b0;
      mism_q      <= 1'b0;
      bcast_q     <= 1'b1;
      mcast_q     <= 1'b0;
      cnt_q       <= 3'd0;
      stat_q      <= 4'b0000;
      ram_vld_q   <= 1'b0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tdata_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      drop_q      <= drop_d;
      mism_q      <= mism_d;
      bcast_q     <= bcast_d;
      mcast_q     <= mcast_d;
      cnt_q       <= cnt_d;
      stat_q      <= stat_d;
      if (fetch) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (fetch)                      ram_vld_q <= 1'b1;
      else if (ram_vld_q && out_rdy)  ram_vld_q <= 1'b0;
      if (out_rdy) begin
        m_tvalid_q <= ram_vld_q;
        if (ram_vld_q) begin
          m_tlast_q <= ram_q[DATA_WIDTH];
          m_tdata_q <= ram_q[DATA_WIDTH-1:0];
        end
      end
    end
  end

  assign m_axis_tvalid     = m_tvalid_q;
  assign m_axis_tlast      = m_tlast_q;
  assign m_axis_tdata      = m_tdata_q;
  assign status_good_frame = stat_q[3];
  assign status_bad_frame  = stat_q[2];
  assign status_filtered   = stat_q[1];
  assign status_overflow   = stat_q[0];

endmodule

// File: tb/tb_eth_rx_frame_filter_fifo.sv
// Randomized bench for eth_rx_frame_filter_fifo: frame-level outcome model plus
// an output byte scoreboard and stall-stability monitor.
module tb_eth_rx_frame_filter_fifo;
  localparam int DEPTH = 2048;
  localparam logic [3:0] ST_GOOD = 4'b1000, ST_BAD = 4'b0100, ST_FILT = 4'b0010,
                         ST_OVF = 4'b0001;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] s_tdata, m_tdata;
  logic s_tvalid, s_tlast, s_tuser, m_tvalid, m_tready, m_tlast;
  logic [47:0] local_mac;
  logic promisc;
  logic st_good, st_bad, st_filt, st_ovf;

  always #5 clk = ~clk;

  eth_rx_frame_filter_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .MAC_FILTER_ENABLE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast),
    .local_mac(local_mac), .promisc(promisc),
    .status_good_frame(st_good), .status_bad_frame(st_bad),
    .status_filtered(st_filt), .status_overflow(st_ovf)
  );

  int n_chk = 0, n_err = 0;
  int n_good_seen = 0, n_good_exp = 0;
  int rdy_mode = 0;        // 0: always ready, 1: never ready, 2: random 50%
  bit gaps = 1'b0;
  logic [8:0] sb[$];       // expected {tlast, data} on m_axis

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Frame-level outcome from the filtering rules.
  function automatic logic [3:0] model(input logic [7:0] fr[$], input bit tuser, input bit ovf);
    logic [47:0] dst;
    if (ovf) return ST_OVF;
    if (tuser || fr.size() < 6) return ST_BAD;
    dst = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
    if (promisc || dst == local_mac || dst == 48'hFFFF_FFFF_FFFF || fr[0][0]) return ST_GOOD;
    return ST_FILT;
  endfunction

  task automatic mk_frame(input logic [47:0] dst, input int len, output logic [7:0] fr[$]);
    fr = {};
    for (int i = 0; i < len; i++)
      if (i < 6) fr.push_back(dst[47-8*i -: 8]);
      else       fr.push_back(8'($urandom));
  endtask

  task automatic send(input logic [7:0] fr[$], input bit tuser, input logic [3:0] exp_st);
    for (int i = 0; i < fr.size(); i++) begin
      if (gaps && ($urandom % 8 == 0)) begin
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
      end
      @(posedge clk); #1;
      s_tvalid = 1'b1;
      s_tdata  = fr[i];
      s_tlast  = (i == fr.size() - 1);
      s_tuser  = s_tlast ? tuser : 1'($urandom);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    chk("status_pulse", {st_good, st_bad, st_filt, st_ovf}, exp_st);
    if (exp_st == ST_GOOD) begin
      n_good_exp++;
      for (int i = 0; i < fr.size(); i++) sb.push_back({i == fr.size() - 1, fr[i]});
    end
    @(posedge clk); #1;
    chk("status_clear", {st_good, st_bad, st_filt, st_ovf}, 4'b0000);
  endtask

  task automatic drain(input int maxcyc);
    int c = 0;
    while (sb.size() != 0 && c < maxcyc) begin
      @(posedge clk); c++;
    end
    chk("drain_left", sb.size(), 0);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'b0;
        default: m_tready = 1'($urandom);
      endcase
    end
  end

  // Output monitor: scoreboard order and hold-while-stalled.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall)
        chk("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_last, prev_data});
      if (m_tvalid && m_tready) begin
        if (sb.size() > 0) e = {1'b0, sb.pop_front()};
        else               e = 10'h200;
        chk("out_beat", {1'b0, m_tlast, m_tdata}, e);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      if (st_good) n_good_seen++;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    logic [47:0] d;
    int len, c, g0;
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; s_tdata = 8'h00;
    m_tready = 1'b1; promisc = 1'b0; local_mac = 48'h02_00_00_00_00_01;
    repeat (3) @(posedge clk); #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_status", {st_good, st_bad, st_filt, st_ovf}, 4'b0000);
    rst = 1'b0;

    // 1: good unicast frame, latency from input tlast
    mk_frame(local_mac, 64, fr);
    send(fr, 1'b0, model(fr, 1'b0, 1'b0));
    chk("lat_cycle1", m_tvalid, 0);
    @(posedge clk); #1;
    chk("lat_cycle2", m_tvalid, 1);
    chk("lat_first", m_tdata, fr[0]);
    drain(500);

    // 2: errored frame then good broadcast
    mk_frame(local_mac, 64, fr);
    send(fr, 1'b1, model(fr, 1'b1, 1'b0));
    mk_frame(48'hFFFF_FFFF_FFFF, 60, fr);
    send(fr, 1'b0, model(fr, 1'b0, 1'b0));
    drain(500);

    // 3: filtering, promiscuous, multicast
    mk_frame(48'h02_00_00_00_00_02, 64, fr);
    send(fr, 1'b0, model(fr, 1'b0, 1'b0));
    promisc = 1'b1;
    send(fr, 1'b0, model(fr, 1'b0, 1'b0));
    promisc = 1'b0;
    mk_frame(48'h01_00_5E_00_00_01, 64, fr);
    send(fr, 1'b0, model(fr, 1'b0, 1'b0));
    drain(500);

    // 4: overflow while downstream is stalled
    rdy_mode = 1;
    for (int k = 0; k < 3; k++) begin
      mk_frame(local_mac, 1500, fr);
      send(fr, 1'b0, model(fr, 1'b0, k != 0));
    end
    chk("ovf_queued", sb.size(), 1500);
    rdy_mode = 0;
    drain(3000);
    mk_frame(local_mac, 100, fr);
    send(fr, 1'b0, model(fr, 1'b0, 1'b0));
    drain(500);

    // 5: runts and the 6-byte boundary
    mk_frame(local_mac, 4, fr);
    send(fr, 1'b0, model(fr, 1'b0, 1'b0));
    mk_frame(local_mac, 5, fr);
    send(fr, 1'b0, model(fr, 1'b0, 1'b0));
    mk_frame(local_mac, 6, fr);
    send(fr, 1'b0, model(fr, 1'b0, 1'b0));
    mk_frame(48'h02_00_00_00_00_03, 6, fr);
    send(fr, 1'b0, model(fr, 1'b0, 1'b0));
    drain(500);

    // reset in mid-frame, then a fresh frame
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      s_tvalid = 1'b1; s_tdata = 8'($urandom); s_tlast = 1'b0;
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("midrst_tvalid", m_tvalid, 0);
    rst = 1'b0;
    mk_frame(local_mac, 20, fr);
    send(fr, 1'b0, model(fr, 1'b0, 1'b0));
    drain(500);

    // 6: random traffic with backpressure and pointer wrap
    rdy_mode = 2; gaps = 1'b1;
    g0 = n_good_seen;
    for (int k = 0; k < 200; k++) begin
      if (k == 19)          len = 1518;
      else if (k % 20 == 9) len = $urandom_range(121, 1518);
      else                  len = $urandom_range(6, 120);
      case ($urandom % 3)
        0:       d = local_mac;
        1:       d = 48'hFFFF_FFFF_FFFF;
        default: begin d = {$urandom, $urandom}; d[40] = 1'b1; end
      endcase
      mk_frame(d, len, fr);
      c = 0;
      while (sb.size() + len + 8 > DEPTH && c < 20000) begin
        @(posedge clk); c++;
      end
      chk("fit_wait_timeout", c >= 20000, 0);
      send(fr, 1'b0, model(fr, 1'b0, 1'b0));
    end
    drain(20000);
    chk("rand_good_count", n_good_seen - g0, 200);
    chk("total_good_count", n_good_seen, n_good_exp);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
